dot_row_feeder: RTL

- Producer side of the 8-wide dot-product row interface: streams pairs of 8x32-bit row packages into the dot-product unit and collects its scalar result.
- Fetches packages from two row memories (A and B, synchronous read) and drives the consumer's job reset, package count, row buses and `outsider_read_now` strobe.
- Returns the result to the controller above it with a start/done handshake.

---
 rtl/dot_pkg.sv | 14 +
 rtl/row_pkg_fetcher.sv | 34 +++
 rtl/dot_row_feeder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// dot_pkg: shared widths and FSM encoding for the dot-product row feeder
package dot_pkg;
    localparam int DEF_NO_OF_UNITS   = 8;
    localparam int DEF_ELEMENT_WIDTH = 32;
    localparam int DEF_PKG_W         = DEF_NO_OF_UNITS * DEF_ELEMENT_WIDTH;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_JOBRST  = 3'd1;
    localparam logic [2:0] S_FETCH   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_WAITFIN = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;
endpackage

// File: rtl/row_pkg_fetcher.sv
// row_pkg_fetcher: row-memory address/read strobe and one-cycle capture of the A/B packages
module row_pkg_fetcher
    import dot_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int W      = DEF_PKG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic              capture,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] idx,
    input  logic [W-1:0]      mem_a_data,
    input  logic [W-1:0]      mem_b_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      first_row,
    output logic [W-1:0]      second_row
);
    assign mem_rd_en = fetch;
    assign mem_addr  = fetch ? base + idx : '0;

    // rows change only on capture, so they stay put across the strobe and its gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_row  <= '0;
            second_row <= '0;
        end else if (capture) begin
            first_row  <= mem_a_data;
            second_row <= mem_b_data;
        end
    end
endmodule

// File: rtl/dot_row_feeder.sv
// dot_row_feeder: streams A/B row packages into the dot-product unit and returns its result
module dot_row_feeder
    import dot_pkg::*;
#(
    parameter int NO_OF_UNITS    = DEF_NO_OF_UNITS,
    parameter int ELEMENT_WIDTH  = DEF_ELEMENT_WIDTH,
    parameter int ADDR_W         = 10,
    parameter int PKG_GAP        = 2,
    parameter int FINISH_TIMEOUT = 4096
) (
    input  logic                                 clk,
    input  logic                                 main_reset,
    input  logic                                 start,
    input  logic [ADDR_W-1:0]                    base_addr,
    input  logic [31:0]                          no_of_multiples,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 timeout,
    output logic [ELEMENT_WIDTH-1:0]             result,
    output logic                                 mem_rd_en,
    output logic [ADDR_W-1:0]                    mem_addr,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] mem_a_data,
    input  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] mem_b_data,
    output logic                                 dp_reset,
    output logic [31:0]                          dp_no_of_multiples,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] dp_first_row,
    output logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] dp_second_row,
    output logic                                 outsider_read_now,
    input  logic                                 dp_finish,
    input  logic [ELEMENT_WIDTH-1:0]             dp_dot_product
);
    localparam int RW = NO_OF_UNITS * ELEMENT_WIDTH;

    logic [2:0]               state;
    logic [ADDR_W-1:0]        base;
    logic [31:0]              pkg_cnt;
    logic [31:0]              idx;
    logic [31:0]              wcnt;
    logic                     fin_flag;
    logic [ELEMENT_WIDTH-1:0] fin_val;

    assign busy               = state != S_IDLE && state != S_DONE;
    assign done               = state == S_DONE;
    assign dp_reset           = state == S_JOBRST;
    assign outsider_read_now  = state == S_PRESENT;
    assign dp_no_of_multiples = pkg_cnt;

    row_pkg_fetcher #(.ADDR_W(ADDR_W), .W(RW)) u_fetch (
        .clk        (clk),
        .rst        (main_reset),
        .fetch      (state == S_FETCH),
        .capture    (state == S_CAPTURE),
        .base       (base),
        .idx        (idx[ADDR_W-1:0]),
        .mem_a_data (mem_a_data),
        .mem_b_data (mem_b_data),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .first_row  (dp_first_row),
        .second_row (dp_second_row)
    );

    // job sequencing; an early dp_finish is kept (flag and value) until WAITFIN consumes it
    always_ff @(posedge clk or posedge main_reset) begin
        if (main_reset) begin
            state    <= S_IDLE;
            base     <= '0;
            pkg_cnt  <= '0;
            idx      <= '0;
            wcnt     <= '0;
            fin_flag <= 1'b0;
            fin_val  <= '0;
            result   <= '0;
            timeout  <= 1'b0;
        end else begin
            if (dp_finish && busy) begin
                fin_flag <= 1'b1;
                fin_val  <= dp_dot_product;
            end
            case (state)
                S_IDLE: if (start) begin
                    base     <= base_addr;
                    pkg_cnt  <= no_of_multiples;
                    idx      <= '0;
                    fin_flag <= 1'b0;
                    result   <= '0;
                    timeout  <= 1'b0;
                    state    <= no_of_multiples == 32'd0 ? S_DONE : S_JOBRST;
                end
                S_JOBRST:  state <= S_FETCH;
                S_FETCH:   state <= S_CAPTURE;
                S_CAPTURE: state <= S_PRESENT;
                S_PRESENT: begin
                    idx   <= idx + 32'd1;
                    wcnt  <= '0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    wcnt <= wcnt + 32'd1;
                    if (wcnt + 32'd1 >= PKG_GAP) begin
                        wcnt  <= '0;
                        state <= idx < pkg_cnt ? S_FETCH : S_WAITFIN;
                    end
                end
                S_WAITFIN: begin
                    wcnt <= wcnt + 32'd1;
                    if (dp_finish || fin_flag) begin
                        result <= dp_finish ? dp_dot_product : fin_val;
                        state  <= S_DONE;
                    end else if (wcnt == FINISH_TIMEOUT - 1) begin
                        timeout <= 1'b1;
                        result  <= '0;
                        state   <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
